// File: rtl/spike_filter_bank_if.sv
// Spike-event and readout streams of spike_filter_bank.
//   in_*  : spike events (tag, count) with valid/ready
//   out_* : filter readouts (index, pre-decay state) with valid/ready
// slave is the filter bank's view; master is the producer/consumer's view.
interface spike_filter_bank_if #(
    parameter int FW     = 10,
    parameter int NCT    = 10,
    parameter int NSTATE = 27
);
    logic              in_valid;
    logic              in_ready;
    logic [FW-1:0]     in_tag;
    logic [NCT-1:0]    in_ct;
    logic              out_valid;
    logic              out_ready;
    logic [FW-1:0]     out_idx;
    logic [NSTATE-1:0] out_state;

    modport slave (
        input  in_valid, in_tag, in_ct, out_ready,
        output in_ready, out_valid, out_idx, out_state
    );

    modport master (
        output in_valid, in_tag, in_ct, out_ready,
        input  in_ready, out_valid, out_idx, out_state
    );
endinterface

// File: rtl/spike_filter_bank.sv
// Bank of first-order low-pass spike filters held in one state memory.
// Spike events add inc_const[bank]*ct (saturating) to a filter's state;
// an update sweep reads out every used filter and multiplies it by
// dec_const[bank]; a clear sweep zeroes every used filter.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   bus                spike input / readout output streams (slave side)
//   update_pulse       request a decay sweep
//   clear_pulse        request a zeroing sweep
//   filts_used         filters 0..filts_used-1 are active (<= NFILTS)
//   inc_const          per-bank increment, NFRAC fractional bits
//   dec_const          per-bank decay factor, 0.NSTATE format
//   overflow           sticky: an increment saturated
//   missed_update      sticky: update_pulse while an update was pending
//   busy               sweep sequencer not idle
module spike_filter_bank #(
    parameter int NFILTS = 1024,
    parameter int NSTATE = 27,
    parameter int NFRAC  = 9,
    parameter int NCT    = 10,
    parameter int NBANK  = 4,
    localparam int FW    = $clog2(NFILTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    spike_filter_bank_if.slave      bus,
    input  logic                    update_pulse,
    input  logic                    clear_pulse,
    input  logic [FW:0]             filts_used,
    input  logic [NBANK*NSTATE-1:0] inc_const,
    input  logic [NBANK*NSTATE-1:0] dec_const,
    output logic                    overflow,
    output logic                    missed_update,
    output logic                    busy
);
    localparam int BW = $clog2(NBANK);
    localparam logic [NSTATE-1:0] SMAX = '1;

    // Increments are integer counts times an NFRAC-fraction constant, so the
    // product already lands in the state's fixed-point format.
    if (NFRAC >= NSTATE) begin : g_bad_nfrac
        $error("NFRAC must be smaller than NSTATE");
    end

    typedef enum logic [2:0] {IDLE, PRE2, PRE1, SWEEP, POST2, POST1} state_t;
    typedef enum logic [1:0] {OP_INC, OP_DEC, OP_CLR} op_t;

    state_t          state;
    logic            sweep_clr;
    logic [FW:0]     k;
    logic            upd_pend, clr_pend;
    logic            stall;

    // issue stage
    logic            iss_vld;
    op_t             iss_op;
    logic [FW-1:0]   iss_idx;
    logic [NCT-1:0]  iss_ct;

    // read stage
    logic            s1_vld;
    op_t             s1_op;
    logic [FW-1:0]   s1_idx;
    logic [NCT-1:0]  s1_ct;
    logic [NSTATE-1:0] rdata, fwd_data, cur;
    logic            fwd_hit;

    logic [NSTATE-1:0] mem [NFILTS];

    logic [BW-1:0]          bank;
    logic [NSTATE-1:0]      inc_b, dec_b, dec_wb, wdata;
    logic [NSTATE+NCT-1:0]  prod;
    logic [NSTATE+NCT:0]    sum;
    logic                   sat, wr_en;

    assign stall = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = (state == IDLE) & bus.in_valid & ~stall & ~upd_pend & ~clr_pend;

    always_comb begin
        iss_vld = 1'b0;
        iss_op  = OP_INC;
        iss_idx = bus.in_tag;
        iss_ct  = bus.in_ct;
        // out-of-range tags are consumed without touching memory
        if (bus.in_ready && ({1'b0, bus.in_tag} < filts_used))
            iss_vld = 1'b1;
        if (state == SWEEP && !stall && k < filts_used) begin
            iss_vld = 1'b1;
            iss_op  = sweep_clr ? OP_CLR : OP_DEC;
            iss_idx = k[FW-1:0];
        end
    end

    // Sweep sequencer. PRE/POST bubbles keep a sweep read from overtaking
    // the write of the op issued just before it (and vice versa).
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            sweep_clr     <= 1'b0;
            k             <= '0;
            upd_pend      <= 1'b0;
            clr_pend      <= 1'b0;
            missed_update <= 1'b0;
        end else begin
            if (update_pulse) begin
                upd_pend <= 1'b1;
                if (upd_pend) missed_update <= 1'b1;
            end
            if (clear_pulse) clr_pend <= 1'b1;
            if (!stall) begin
                case (state)
                    IDLE: begin
                        // clear wins; a simultaneous update stays pending
                        if (clr_pend) begin
                            state     <= PRE2;
                            busy      <= 1'b1;
                            sweep_clr <= 1'b1;
                            clr_pend  <= clear_pulse;
                        end else if (upd_pend) begin
                            state     <= PRE2;
                            busy      <= 1'b1;
                            sweep_clr <= 1'b0;
                            upd_pend  <= update_pulse;
                        end
                    end
                    PRE2: state <= PRE1;
                    PRE1: begin
                        k     <= '0;
                        state <= (filts_used == '0) ? POST2 : SWEEP;
                    end
                    SWEEP: begin
                        // live filts_used: a shrink mid-sweep ends it early
                        k <= k + 1'b1;
                        if (k + 1'b1 >= filts_used) state <= POST2;
                    end
                    POST2: state <= POST1;
                    POST1: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Back-to-back increments to one tag: the second read coincides with the
    // first write, so the just-written value is forwarded.
    assign cur   = fwd_hit ? fwd_data : rdata;
    assign bank  = s1_idx[BW-1:0];
    assign inc_b = inc_const[bank*NSTATE +: NSTATE];
    assign dec_b = dec_const[bank*NSTATE +: NSTATE];
    assign prod  = {{NCT{1'b0}}, inc_b} * {{NSTATE{1'b0}}, s1_ct};
    assign sum   = {1'b0, prod} + {{(NCT+1){1'b0}}, cur};
    assign sat   = |sum[NSTATE+NCT:NSTATE];
    assign dec_wb = NSTATE'(({{NSTATE{1'b0}}, cur} * {{NSTATE{1'b0}}, dec_b}) >> NSTATE);
    assign wr_en = s1_vld & ~reset;

    always_comb begin
        wdata = '0;
        case (s1_op)
            OP_INC:  wdata = sat ? SMAX : sum[NSTATE-1:0];
            OP_DEC:  wdata = dec_wb;
            default: wdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_idx   <= '0;
            bus.out_state <= '0;
            overflow      <= 1'b0;
        end else if (!stall) begin
            s1_vld        <= iss_vld;
            bus.out_valid <= s1_vld && s1_op == OP_DEC;
            bus.out_idx   <= s1_idx;
            bus.out_state <= cur;
            if (s1_vld && s1_op == OP_INC && sat) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_op    <= iss_op;
            s1_idx   <= iss_idx;
            s1_ct    <= iss_ct;
            rdata    <= mem[iss_idx];
            fwd_hit  <= wr_en && (s1_idx == iss_idx);
            fwd_data <= wdata;
            if (wr_en) mem[s1_idx] <= wdata;
        end
    end
endmodule

// File: tb/tb_spike_filter_bank.sv
module tb_spike_filter_bank;
    localparam int NFILTS = 1024, NSTATE = 27, NCT = 10, NBANK = 4, FW = 10;
    localparam longint SMAX = (64'd1 << NSTATE) - 1;

    logic clk = 1'b0;
    logic reset;
    logic update_pulse, clear_pulse;
    logic [FW:0] filts_used;
    logic [NBANK*NSTATE-1:0] inc_const, dec_const;
    logic overflow, missed_update, busy;

    always #5 clk = ~clk;

    spike_filter_bank_if #(.FW(FW), .NCT(NCT), .NSTATE(NSTATE)) bus ();

    spike_filter_bank #(.NFILTS(NFILTS), .NSTATE(NSTATE), .NFRAC(9), .NCT(NCT), .NBANK(NBANK)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .update_pulse(update_pulse), .clear_pulse(clear_pulse),
        .filts_used(filts_used), .inc_const(inc_const), .dec_const(dec_const),
        .overflow(overflow), .missed_update(missed_update), .busy(busy)
    );

    int nvec = 0, nmis = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // model: filter states, next expected readout index, readout log
    longint mst [NFILTS];
    int     exp_k = 0;
    int     lidx[$];
    longint lst[$];
    longint s;
    int     b;

    always @(negedge clk) begin
        if (reset) begin
            exp_k = 0;
        end else begin
            if (bus.in_valid && bus.in_ready && {1'b0, bus.in_tag} < filts_used) begin
                b = int'(bus.in_tag) % NBANK;
                s = mst[bus.in_tag] + longint'(inc_const[b*NSTATE +: NSTATE]) * longint'(bus.in_ct);
                mst[bus.in_tag] = (s > SMAX) ? SMAX : s;
            end
            if (clear_pulse)
                for (int i = 0; i < int'(filts_used); i++) mst[i] = 0;
            if (bus.out_valid && bus.out_ready) begin
                chk("ro_idx", bus.out_idx, exp_k);
                chk("ro_state", bus.out_state, mst[bus.out_idx]);
                lidx.push_back(int'(bus.out_idx));
                lst.push_back(longint'(bus.out_state));
                b = int'(bus.out_idx) % NBANK;
                mst[bus.out_idx] = (mst[bus.out_idx] * longint'(dec_const[b*NSTATE +: NSTATE])) >> NSTATE;
                exp_k = (exp_k + 1 >= int'(filts_used)) ? 0 : exp_k + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_upd();
        update_pulse = 1'b1;
        tick();
        update_pulse = 1'b0;
    endtask

    task automatic pulse_clr();
        clear_pulse = 1'b1;
        tick();
        clear_pulse = 1'b0;
    endtask

    task automatic wait_quiet(input string nm);
        int q = 0, n = 0;
        while (q < 4 && n < 5000) begin
            tick();
            n++;
            q = busy ? 0 : q + 1;
        end
        if (q < 4) begin
            nvec++; nmis++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", nm, n);
        end
    endtask

    task automatic spike(input int tag, input int ct);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_tag   = FW'(tag);
        bus.in_ct    = NCT'(ct);
        #1;
        while (!bus.in_ready && n < 5000) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            nvec++; nmis++;
            $display("FAIL spike_accept: tag %0d not accepted, expected in_ready=1", tag);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_ro(input string nm, input int pos, input int idx, input longint val);
        if (lidx.size() > pos) begin
            chk({nm, "_idx"}, lidx[pos], idx);
            chk({nm, "_val"}, lst[pos], val);
        end else begin
            nvec++; nmis++;
            $display("FAIL %s: readout %0d missing, expected (%0d,%0d)", nm, pos, idx, val);
        end
    endtask

    task automatic clr_log();
        lidx.delete();
        lst.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset = 1'b1;
        update_pulse = 1'b0; clear_pulse = 1'b0;
        filts_used = 2; inc_const = '0; dec_const = '0;
        bus.in_valid = 1'b0; bus.in_tag = '0; bus.in_ct = '0; bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_missed", missed_update, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        reset = 1'b0;
        tick();

        // basic increment then update
        inc_const = {4{27'd512}}; dec_const = '0; filts_used = 2;
        pulse_clr(); wait_quiet("t1_clr");
        spike(0, 1); spike(1, 2);
        clr_log(); pulse_upd(); wait_quiet("t1_upd");
        chk("t1_count", lidx.size(), 2);
        chk_ro("t1_r0", 0, 0, 512);
        chk_ro("t1_r1", 1, 1, 1024);
        clr_log(); pulse_upd(); wait_quiet("t1_upd2");
        chk_ro("t1_z0", 0, 0, 0);
        chk_ro("t1_z1", 1, 1, 0);

        // decay by 0.5 and 0; back-to-back same-tag spikes
        inc_const = {27'd0, 27'd0, 27'd1000, 27'd500};
        dec_const = {27'd0, 27'd0, 27'd0, 27'd67108864};
        pulse_clr(); wait_quiet("t2_clr");
        spike(0, 1); spike(0, 1); spike(1, 1);
        clr_log(); pulse_upd(); wait_quiet("t2_upd1");
        pulse_upd(); wait_quiet("t2_upd2");
        chk_ro("t2_a0", 0, 0, 1000);
        chk_ro("t2_a1", 1, 1, 1000);
        chk_ro("t2_b0", 2, 0, 500);
        chk_ro("t2_b1", 3, 1, 0);

        // saturation
        inc_const = {4{27'd67108864}}; dec_const = '0;
        pulse_clr(); wait_quiet("t3_clr");
        chk("t3_ovf_before", overflow, 0);
        spike(0, 1023);
        repeat (3) tick();
        chk("t3_ovf_after", overflow, 1);
        spike(0, 1);
        clr_log(); pulse_upd(); wait_quiet("t3_upd");
        chk_ro("t3_sat", 0, 0, SMAX);
        chk_ro("t3_other", 1, 1, 0);

        // backpressure mid-sweep
        filts_used = 4; inc_const = {4{27'd512}}; dec_const = {4{27'd67108864}};
        pulse_clr(); wait_quiet("t4_clr");
        for (int i = 0; i < 4; i++) spike(i, i + 1);
        clr_log(); pulse_upd();
        repeat (5) tick();
        bus.out_ready = 1'b0;
        repeat (2) tick();
        chk("t4_stall_valid", bus.out_valid, 1);
        repeat (3) tick();
        bus.out_ready = 1'b1;
        wait_quiet("t4_upd1");
        chk("t4_count", lidx.size(), 4);
        for (int i = 0; i < 4; i++) chk_ro("t4_a", i, i, 512 * (i + 1));
        clr_log(); pulse_upd(); wait_quiet("t4_upd2");
        for (int i = 0; i < 4; i++) chk_ro("t4_b", i, i, 256 * (i + 1));

        // spike coinciding with update request, out-of-range tag
        filts_used = 5;
        pulse_clr(); wait_quiet("t5_clr");
        filts_used = 4;
        spike(3, 1);
        clr_log();
        bus.in_valid = 1'b1; bus.in_tag = 3; bus.in_ct = 1; update_pulse = 1'b1;
        #1;
        chk("t5_same_cycle_ready", bus.in_ready, 1);
        tick();
        update_pulse = 1'b0;
        bus.in_tag = 4; bus.in_ct = 5;
        #1;
        chk("t5_blocked", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        spike(4, 5);
        wait_quiet("t5_upd1");
        chk_ro("t5_hazard", 3, 3, 1024);
        filts_used = 5;
        clr_log(); pulse_upd(); wait_quiet("t5_upd2");
        chk_ro("t5_decayed", 3, 3, 512);
        chk_ro("t5_dropped", 4, 4, 0);

        // missed update
        filts_used = 2;
        chk("t6_missed_before", missed_update, 0);
        clr_log(); pulse_upd(); tick();
        chk("t6_busy", busy, 1);
        update_pulse = 1'b1;
        repeat (3) tick();
        update_pulse = 1'b0;
        wait_quiet("t6_upd");
        chk("t6_missed_after", missed_update, 1);
        chk("t6_count", lidx.size(), 4);

        // reset mid-sweep
        filts_used = 200;
        pulse_clr(); wait_quiet("t7_clr");
        pulse_upd();
        repeat (20) tick();
        chk("t7_streaming", bus.out_valid, 1);
        reset = 1'b1;
        tick();
        chk("t7_rst_valid", bus.out_valid, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_ovf", overflow, 0);
        chk("t7_rst_missed", missed_update, 0);
        reset = 1'b0;
        cnt = 0;
        repeat (20) begin
            tick();
            if (bus.out_valid) cnt++;
        end
        chk("t7_no_readouts", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
